// File: rtl/mips_mem_pkg.sv
// Shared definitions for the byte-lane MIPS data memory.
//   SIZE_*         access_size encodings (2'b11 is reserved and always rejected)
//   mem_state_t    top-level FSM states: CLEAR wipes the array, READY serves requests
//   is_misaligned  1 when a request of the given size cannot start at the given lane offset
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = |off;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// Request/response bundle between the MEM stage and the data memory.
//   access_address  byte address            read_data   extended load result
//   read_enable     load request            read_valid  1-cycle pulse after accepted load
//   write_enable    store request           misaligned  1-cycle pulse after rejected request
//   access_size     byte/half/word          ready       requests accepted this cycle
//   sign_extend     load extension mode
//   write_data      right-justified store data
// master drives requests, slave (the memory) drives responses.
interface data_memory_bytelane_if;

  logic [31:0] access_address;
  logic        read_enable;
  logic        write_enable;
  logic [1:0]  access_size;
  logic        sign_extend;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        ready;

  modport master (
    output access_address, read_enable, write_enable, access_size, sign_extend, write_data,
    input  read_data, read_valid, misaligned, ready
  );

  modport slave (
    input  access_address, read_enable, write_enable, access_size, sign_extend, write_data,
    output read_data, read_valid, misaligned, ready
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the data memory.
//   Store side: size, off, write_data  -> byte_en (per-byte write strobes), write_lanes
//               (data shifted into its byte lanes).
//   Load side:  load_word, load_off, load_size, load_sign -> load_data (lane extracted and
//               sign/zero-extended; word loads pass through untouched).
// Alignment is checked by the caller; misaligned combinations here produce don't-care strobes.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] write_data,
  output logic [3:0]  byte_en,
  output logic [31:0] write_lanes,
  input  logic [31:0] load_word,
  input  logic [1:0]  load_off,
  input  logic [1:0]  load_size,
  input  logic        load_sign,
  output logic [31:0] load_data
);

  logic [31:0] load_shifted;

  always_comb begin
    byte_en     = 4'h0;
    write_lanes = write_data << {off, 3'b000};
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << off;
      SIZE_HALF: byte_en = 4'b0011 << off;
      SIZE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'h0;
    endcase
  end

  always_comb begin
    load_shifted = load_word >> {load_off, 3'b000};
    case (load_size)
      SIZE_BYTE: load_data = {{24{load_sign & load_shifted[7]}}, load_shifted[7:0]};
      SIZE_HALF: load_data = {{16{load_sign & load_shifted[15]}}, load_shifted[15:0]};
      default:   load_data = load_word;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// MIPS data memory for the MEM stage: byte-addressed, byte-lane stores, extending loads with
// a registered 1-cycle read, misalignment flagging, and a sequential clear after reset.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    data_memory_bytelane_if.slave (requests in, read_data/read_valid/misaligned/ready out)
// Parameters:
//   DEPTH_LOG2      word-address bits; the array holds 2**DEPTH_LOG2 32-bit words
//   CLEAR_ON_RESET  1: zero every word after reset before raising ready; 0: ready right away
module data_memory_bytelane
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  data_memory_bytelane_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem [0:DEPTH-1];

  mem_state_t            state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  clear_we;
  logic                  ready_q;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            off;
  logic                  mis;
  logic                  accept;
  logic                  store_go;
  logic                  load_go;
  logic                  reject;

  logic [3:0]  byte_en;
  logic [31:0] write_lanes;
  logic [31:0] load_data;

  logic [31:0] rd_word_q;
  logic [1:0]  rd_off_q;
  logic [1:0]  rd_size_q;
  logic        rd_sign_q;
  logic        read_valid_q;
  logic        mis_q;

  // Address bits above the array wrap and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.access_address[31:DEPTH_LOG2+2];

  // ---------------------------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clear_we = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        ptr_d    = ptr_q + DEPTH_LOG2'(1);
        if (&ptr_q) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // Registered so ready rises the cycle after the final clear write.
      ready_q <= (state_d == READY);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  assign word_idx = bus.access_address[DEPTH_LOG2+1:2];
  assign off      = bus.access_address[1:0];
  assign mis      = is_misaligned(bus.access_size, off);
  assign accept   = ready_q & ~reset;
  assign store_go = accept & bus.write_enable & ~mis;
  assign load_go  = accept & bus.read_enable & ~mis;
  assign reject   = accept & (bus.read_enable | bus.write_enable) & mis;

  mem_lane_align u_lane_align (
    .size        (bus.access_size),
    .off         (off),
    .write_data  (bus.write_data),
    .byte_en     (byte_en),
    .write_lanes (write_lanes),
    .load_word   (rd_word_q),
    .load_off    (rd_off_q),
    .load_size   (rd_size_q),
    .load_sign   (rd_sign_q),
    .load_data   (load_data)
  );

  // ---------------------------------------------------------------------------------------------
  // Array: per-byte write enables, no reset so it maps onto block RAM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear_we && !reset) begin
      mem[ptr_q] <= '0;
    end else if (store_go) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= write_lanes[8*b +: 8];
        end
      end
    end
  end

  // Read port samples the pre-write word, giving read-first behaviour on same-cycle access.
  // Lane extraction happens after the register so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_q    <= '0;
      rd_off_q     <= 2'b00;
      rd_size_q    <= SIZE_WORD;
      rd_sign_q    <= 1'b0;
      read_valid_q <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      read_valid_q <= load_go;
      mis_q        <= reject;
      if (load_go) begin
        rd_word_q <= mem[word_idx];
        rd_off_q  <= off;
        rd_size_q <= bus.access_size;
        rd_sign_q <= bus.sign_extend;
      end else if (reject) begin
        rd_word_q <= '0;
        rd_off_q  <= 2'b00;
        rd_size_q <= SIZE_WORD;
        rd_sign_q <= 1'b0;
      end
    end
  end

  assign bus.read_data  = load_data;
  assign bus.read_valid = read_valid_q;
  assign bus.misaligned = mis_q;
  assign bus.ready      = ready_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed, table-driven bench for data_memory_bytelane at DEPTH_LOG2=4.
module tb_data_memory_bytelane;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_memory_bytelane_if bus ();

  data_memory_bytelane #(
    .DEPTH_LOG2     (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic re, logic we, logic [1:0] size, logic sign,
                              logic [31:0] addr, logic [31:0] wdata, logic ev, logic em,
                              logic [31:0] ed);
    vec_t v;
    v.name = n; v.re = re; v.we = we; v.size = size; v.sign = sign; v.addr = addr;
    v.wdata = wdata; v.exp_valid = ev; v.exp_mis = em; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.read_enable    = re;
    bus.write_enable   = we;
    bus.access_size    = size;
    bus.sign_extend    = sign;
    bus.access_address = addr;
    bus.write_data     = wdata;
  endtask

  // Counts rising edges until ready is seen high; optionally checks no pulses appear meanwhile.
  task automatic wait_ready(input string name, input bit quiet, output int cycles);
    cycles = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (quiet) begin
        check({name, "_no_valid"}, 32'(bus.read_valid), 32'd0);
        check({name, "_no_mis"}, 32'(bus.misaligned), 32'd0);
      end
      if (bus.ready === 1'b1) break;
      if (cycles >= 200) begin
        bad++;
        total++;
        $display("FAIL %s: ready never rose, waited %0d cycles, required 16", name, cycles);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;

    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_valid", 32'(bus.read_valid), 32'd0);
    check("rst_mis", 32'(bus.misaligned), 32'd0);
    check("rst_data", bus.read_data, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear1", 1'b0, cyc);
    check("clear1_cycles", 32'(cyc), 32'd16);

    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk($sformatf("clr_lw%0d", i), 1, 0, 2'b10, 0, 32'(4 * i), 32'h0,
                        1, 0, 32'h0));
    end
    vecs.push_back(mk("sw4",      0, 1, 2'b10, 0, 32'h4,  32'h8899AABC, 0, 0, 32'h0));
    vecs.push_back(mk("sb5",      0, 1, 2'b00, 0, 32'h5,  32'h00000011, 0, 0, 32'h0));
    vecs.push_back(mk("lw4",      1, 0, 2'b10, 0, 32'h4,  32'h0, 1, 0, 32'h889911BC));
    vecs.push_back(mk("lb7",      1, 0, 2'b00, 1, 32'h7,  32'h0, 1, 0, 32'hFFFFFF88));
    vecs.push_back(mk("lbu7",     1, 0, 2'b00, 0, 32'h7,  32'h0, 1, 0, 32'h00000088));
    vecs.push_back(mk("lh6",      1, 0, 2'b01, 1, 32'h6,  32'h0, 1, 0, 32'hFFFF8899));
    vecs.push_back(mk("lhu4",     1, 0, 2'b01, 0, 32'h4,  32'h0, 1, 0, 32'h000011BC));
    vecs.push_back(mk("mis_lw6",  1, 0, 2'b10, 0, 32'h6,  32'h0, 0, 1, 32'h0));
    vecs.push_back(mk("mis_sh5",  0, 1, 2'b01, 0, 32'h5,  32'h1234, 0, 1, 32'h0));
    vecs.push_back(mk("mis_sz3",  1, 0, 2'b11, 0, 32'h0,  32'h0, 0, 1, 32'h0));
    vecs.push_back(mk("lw4_again", 1, 0, 2'b10, 0, 32'h4, 32'h0, 1, 0, 32'h889911BC));
    vecs.push_back(mk("rw_same8", 1, 1, 2'b10, 0, 32'h8,  32'hDEADBEEF, 1, 0, 32'h0));
    vecs.push_back(mk("lw8",      1, 0, 2'b10, 0, 32'h8,  32'h0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lbu9",     1, 0, 2'b00, 0, 32'h9,  32'h0, 1, 0, 32'h000000BE));
    vecs.push_back(mk("lw8_sign", 1, 0, 2'b10, 1, 32'h8,  32'h0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lw_wrap",  1, 0, 2'b10, 0, 32'h48, 32'h0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("sh_a",     0, 1, 2'b01, 0, 32'hA,  32'h0000CAFE, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lw8_sh",   1, 0, 2'b10, 0, 32'h8,  32'h0, 1, 0, 32'hCAFEBEEF));
    vecs.push_back(mk("lhu_a",    1, 0, 2'b01, 0, 32'hA,  32'h0, 1, 0, 32'h0000CAFE));
    vecs.push_back(mk("lh_a",     1, 0, 2'b01, 1, 32'hA,  32'h0, 1, 0, 32'hFFFFCAFE));
    vecs.push_back(mk("idle",     0, 0, 2'b10, 0, 32'h0,  32'h0, 0, 0, 32'hFFFFCAFE));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].re, vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_valid"}, 32'(bus.read_valid), 32'(vecs[i].exp_valid));
      check({vecs[i].name, "_mis"}, 32'(bus.misaligned), 32'(vecs[i].exp_mis));
      check({vecs[i].name, "_data"}, bus.read_data, vecs[i].exp_data);
    end

    // Reset part-way through clear restarts the full sweep; requests meanwhile are ignored.
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("rst2_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear2", 1'b1, cyc);
    check("clear2_cycles", 32'(cyc), 32'd16);

    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    @(posedge clk);
    #1;
    check("post_clear_valid", 32'(bus.read_valid), 32'd1);
    check("post_clear_lwC", bus.read_data, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    #1;
    check("post_clear_lw8", bus.read_data, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
